uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  - Single-clock UART transmitter: accepts one parallel byte on a data_valid strobe and serialises it on TX_OUT.
//  - Frame, LSB first: start(0), DATA_WIDTH data bits, optional parity bit, stop(1).
//  - One bit per clock; no baud divider. The clock is the bit clock, supplied by an upstream prescaler.
//  - busy flags an in-progress frame to the producer.
// PARAMETERS
//  - DATA_WIDTH  8  payload bits per frame
// PORTS
//  - clk         in   1           bit clock; all state updates on rising edge
//  - rstn        in   1           reset; one clock, asynchronous, active-low
//  - P_DATA      in   DATA_WIDTH  parallel payload, sampled only on acceptance
//  - data_valid  in   1           request: P_DATA/par_en/par_typ valid this cycle
//  - par_typ     in   1           0 = even parity, 1 = odd parity
//  - par_en      in   1           1 = insert parity bit after data
//  - TX_OUT      out  1           serial line; idles high
//  - busy        out  1           high while a frame is on the line
// BEHAVIOUR
//  - Reset (async, rstn=0):
//    - state=IDLE, TX_OUT=1, busy=0, shift/parity registers cleared.
//    - Reset mid-frame aborts the frame immediately; the line returns high.
//  - Outputs:
//    - TX_OUT and busy are registered and change only on the rising edge that enters a state (Moore-style, glitch-free).
//  - States:
//    - IDLE:
//      - TX_OUT=1, busy=0.
//      - If data_valid=1 at an edge: latch P_DATA, par_en, par_typ.
//      - Compute parity: even = ^P_DATA, odd = ~^P_DATA.
//      - Go to START.
//    - START: TX_OUT=0, busy=1 for exactly one cycle; then go to DATA with bit index 0.
//    - DATA:
//      - TX_OUT = latched_data[idx], one cycle per bit, idx 0..DATA_WIDTH-1 (LSB first).
//      - After the last bit, go to PARITY if latched par_en=1, else go to STOP.
//    - PARITY: TX_OUT = latched parity bit, one cycle; then go to STOP.
//    - STOP: TX_OUT=1, busy=1, one cycle; then go to IDLE (busy drops on that edge).
//  - Latency:
//    - Start bit is on the line in the cycle after the edge that samples data_valid.
//    - Frame length is 10 cycles without parity, 11 cycles with parity.
//  - Handshake:
//    - data_valid is level-sampled only in IDLE.
//    - data_valid asserted in START/DATA/PARITY/STOP is ignored; it is not queued.
//    - P_DATA, par_en and par_typ changes during a frame have no effect on the frame in flight.
//    - At least one IDLE cycle separates consecutive frames.
//    - data_valid held high continuously starts a new frame on each IDLE cycle.
//  - Bit counter:
//    - Width clog2(DATA_WIDTH).
//    - Compare against DATA_WIDTH-1; no wrap is reachable.
// STRUCTURE
//  - Package uart_tx_pkg:
//    - typedef enum {IDLE, START, DATA, PARITY, STOP} tx_state_t
//    - localparams PAR_EVEN=1'b0, PAR_ODD=1'b1
//    - localparams START_BIT=1'b0, STOP_BIT=1'b1
//  - One sub-module uart_tx_parity: combinational parity from data and par_typ.
//  - Top level holds the FSM, the data latch/bit counter and the output registers.
// TESTING
//  - Even parity:
//    - Stimulus: P_DATA=8'h9C, par_en=1, par_typ=0, 1-cycle data_valid.
//    - Response: start 0, busy=1; then 0,0,1,1,1,0,0,1; parity 0; stop 1.
//  - Odd parity: same payload, par_typ=1 -> same serial data, parity bit 1, stop 1.
//  - No parity: P_DATA=8'h9C, par_en=0 -> start 0, 8 data bits, stop 1; 10-cycle frame; busy low after stop.
//  - Data change mid-frame: change P_DATA to 8'hC3 one cycle after accept -> line still carries 8'h9C.
//  - Ignored request: pulse data_valid during DATA -> no effect; one IDLE cycle follows stop; no second frame.
//  - Reset mid-frame: assert rstn=0 during DATA -> TX_OUT=1 and busy=0 immediately; a clean frame follows after release.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmitter.
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity bit for a payload; even makes the total count of ones even.
module uart_tx_parity
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_o
);
  assign par_o = (par_typ_i == PAR_ODD) ? ~^data_i : ^data_i;
endmodule

// File: rtl/uart_tx.sv
// One-bit-per-clock UART transmitter: start, LSB-first data, optional parity, stop.
// TX_OUT and busy are registered and updated on the edge that enters each state.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  par_typ,
  input  logic                  par_en,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  tx_state_t             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         idx_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  par_w;

  uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data_i    (P_DATA),
    .par_typ_i (par_typ),
    .par_o     (par_w)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= STOP_BIT;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          TX_OUT <= STOP_BIT;
          busy   <= 1'b0;
          if (data_valid) begin
            shift_q   <= P_DATA;
            par_en_q  <= par_en;
            par_bit_q <= par_w;
            state_q   <= START;
            TX_OUT    <= START_BIT;
            busy      <= 1'b1;
          end
        end
        START: begin
          // Payload is shifted out from bit 0; the register drains as bits go out.
          TX_OUT  <= shift_q[0];
          shift_q <= shift_q >> 1;
          idx_q   <= '0;
          state_q <= DATA;
        end
        DATA: begin
          if (idx_q == LAST_IDX) begin
            if (par_en_q) begin
              TX_OUT  <= par_bit_q;
              state_q <= PARITY;
            end else begin
              TX_OUT  <= STOP_BIT;
              state_q <= STOP;
            end
          end else begin
            TX_OUT  <= shift_q[0];
            shift_q <= shift_q >> 1;
            idx_q   <= idx_q + 1'b1;
          end
        end
        PARITY: begin
          TX_OUT  <= STOP_BIT;
          state_q <= STOP;
        end
        STOP: begin
          TX_OUT  <= STOP_BIT;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          TX_OUT  <= STOP_BIT;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: a frame-level model queues expected frames,
// a monitor compares the line cycle by cycle as frames appear.
module tb_uart_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] P_DATA;
  logic         data_valid;
  logic         par_typ;
  logic         par_en;
  logic         TX_OUT;
  logic         busy;

  uart_tx #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_typ    (par_typ),
    .par_en     (par_en),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bits;
    int          len;
    int          start_cyc;
  } frame_t;

  frame_t frame_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int next_ok = 0;
  int frames_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame model: line is start, data LSB first, optional parity, stop.
  function automatic frame_t build(input logic [W-1:0] d, input logic pe, input logic pt, input int c);
    frame_t f;
    int ones;
    int n;
    f.bits = '1;
    ones = 0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < W; i++) begin
      f.bits[1+i] = d[i];
      ones += int'(d[i]);
    end
    n = W + 1;
    if (pe) begin
      f.bits[n] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
      n++;
    end
    f.bits[n] = 1'b1;
    f.len = n + 1;
    f.start_cyc = c;
    return f;
  endfunction

  // A request is taken only if the transmitter has returned to idle for at
  // least one cycle since the previous frame occupied len cycles.
  always @(posedge clk) begin
    cyc++;
    if (rstn && data_valid && cyc >= next_ok) begin
      frame_q.push_back(build(P_DATA, par_en, par_typ, cyc));
      next_ok = cyc + (par_en ? W + 3 : W + 2) + 1;
    end
  end

  bit    in_frame = 0;
  int    pos = 0;
  frame_t cur;

  always @(negedge clk) begin
    if (!rstn) begin
      in_frame = 0;
      check("rst_tx", 32'(TX_OUT), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
    end else begin
      if (!in_frame && busy) begin
        if (frame_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          cur = frame_q.pop_front();
          in_frame = 1;
          pos = 0;
          frames_seen++;
          check("start_latency", 32'(cyc), 32'(cur.start_cyc));
        end
      end
      if (in_frame) begin
        check("line_bit", 32'(TX_OUT), 32'(cur.bits[pos]));
        check("busy_in_frame", 32'(busy), 32'd1);
        pos++;
        if (pos == cur.len) in_frame = 0;
      end else if (!busy) begin
        check("idle_line", 32'(TX_OUT), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
    P_DATA = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    frame_q.delete();
    next_ok = 0;
    #1;
    check("async_rst_tx", 32'(TX_OUT), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    tick(n);
    rstn = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((frame_q.size() != 0 || in_frame) && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) check("drain_timeout", 32'd1, 32'd0);
    tick(2);
  endtask

  initial begin
    int seen;
    rstn = 1'b0; P_DATA = '0; data_valid = 1'b0; par_typ = 1'b0; par_en = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(2);

    send(8'h9C, 1'b1, 1'b0);          // even parity
    drain(40);
    send(8'h9C, 1'b1, 1'b1);          // odd parity
    drain(40);
    send(8'h9C, 1'b0, 1'b0);          // no parity, 10-cycle frame
    drain(40);

    send(8'h9C, 1'b0, 1'b0);          // payload/config change after accept
    P_DATA = 8'hC3; par_en = 1'b1; par_typ = 1'b1;
    drain(40);

    seen = frames_seen;
    send(8'hA5, 1'b1, 1'b0);          // request during DATA must be dropped
    tick(3);
    send(8'h5A, 1'b0, 1'b1);
    drain(40);
    tick(5);
    check("ignored_req_frames", 32'(frames_seen - seen), 32'd1);

    P_DATA = 8'h3C; par_en = 1'b0; data_valid = 1'b1;   // held valid: back-to-back frames
    tick(35);
    data_valid = 1'b0;
    drain(40);

    send(8'h9C, 1'b1, 1'b0);          // reset during DATA aborts the frame
    tick(4);
    do_reset(1);
    tick(2);
    send(8'h9C, 1'b1, 1'b0);
    drain(40);

    for (int i = 0; i < 60; i++) begin
      P_DATA = W'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      data_valid = 1'b1;
      tick($urandom_range(1, 3));
      P_DATA = W'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      data_valid = 1'($urandom_range(0, 3) == 0);
      tick($urandom_range(0, 14));
      data_valid = 1'b0;
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(0, 2));
    end
    drain(60);
    check("queue_empty_end", 32'(frame_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
